// File: rtl/weyl_pkg.sv
// ---------------------------------------------------------------------------
// weyl_pkg
// Shared types and elaboration-time helpers for the Weyl stream generator.
//   state_e  : stream FSM states
//   idx_w    : index width for an N-bit stream (clog2(N))
//   qta_w    : quota / compare width (clog2(N)+1, so a quota of N fits)
//   mod_n    : non-negative modulo for parameter arithmetic
//   mod_inv  : inverse of an odd stride modulo a power-of-2 N
// ---------------------------------------------------------------------------
package weyl_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

   function automatic int qta_w(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic int mod_n(input longint x, input int n);
      longint r;
      r = x % longint'(n);
      if (r < 0) r = r + longint'(n);
      return int'(r);
   endfunction

   // Newton iteration x <- x*(2 - s*x) doubles the number of correct low
   // bits each pass; x0 = s is already correct mod 8 for any odd s.
   // Arithmetic wraps mod 2^64, which is consistent with any smaller
   // power-of-2 modulus, so the final mask gives the inverse mod n.
   function automatic int mod_inv(input int s, input int n);
      longint x;
      x = longint'(s);
      for (int i = 0; i < 6; i++) x = x * (longint'(2) - longint'(s) * x);
      return int'(x & longint'(n - 1));
   endfunction

endpackage

// File: rtl/weyl_stream_gen_if.sv
// ---------------------------------------------------------------------------
// weyl_stream_gen_if
// Load and stream handshakes of the Weyl stream generator.
//   load_valid/load_ready/quota : quota vector in (one QW-bit count/channel)
//   out_valid/out_ready         : beat handshake
//   out_bits                    : CHANNELS x LANES beat data
//   out_last                    : final beat of a stream
// slave  : the generator
// master : the environment that loads quotas and consumes beats
// ---------------------------------------------------------------------------
interface weyl_stream_gen_if #(
   parameter int CHANNELS = 2,
   parameter int LANES    = 8,
   parameter int QW       = 7
);
   logic                               load_valid;
   logic                               load_ready;
   logic [CHANNELS-1:0][QW-1:0]        quota;
   logic                               out_valid;
   logic                               out_ready;
   logic [CHANNELS-1:0][LANES-1:0]     out_bits;
   logic                               out_last;

   modport slave (
      input  load_valid, quota, out_ready,
      output load_ready, out_valid, out_bits, out_last
   );

   modport master (
      output load_valid, quota, out_ready,
      input  load_ready, out_valid, out_bits, out_last
   );
endinterface

// File: rtl/weyl_stream_chan.sv
// ---------------------------------------------------------------------------
// weyl_stream_chan
// One output channel: latched quota Q, lane-0 index accumulator and LANES
// comparators. Lane l of the current beat is 1 iff its Weyl index is < Q.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : load accepted, latch quota and restart at beat 0
//   adv_i      : non-final beat accepted, move to next beat
//   stop_i     : final beat accepted with no new load, clear the beat
//   quota_i    : requested ones count (saturated to N)
//   bits_o     : registered beat data for this channel
// ---------------------------------------------------------------------------
module weyl_stream_chan
   import weyl_pkg::*;
#(
   parameter  int N     = 64,
   parameter  int LANES = 8,
   parameter  int SINV  = 49,
   parameter  int INIT  = 0,   // lane-0 index of beat 0: (-B_c)*SINV mod N
   parameter  int STEP  = 8,   // LANES*SINV mod N
   localparam int IW    = idx_w(N),
   localparam int QW    = qta_w(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             adv_i,
   input  logic             stop_i,
   input  logic [QW-1:0]    quota_i,
   output logic [LANES-1:0] bits_o
);

   logic [QW-1:0]    q_q, q_d;
   logic [IW-1:0]    acc_q, acc_d;
   logic [LANES-1:0] bits_q, bits_d, hit;

   always_comb begin
      q_d   = q_q;
      acc_d = acc_q;
      if (start_i) begin
         q_d   = (quota_i > QW'(N)) ? QW'(N) : quota_i;
         acc_d = IW'(INIT);
      end else if (adv_i) begin
         acc_d = acc_q + IW'(STEP);
      end
   end

   // Comparators look at next-state Q/index so the registered beat lines up
   // with the handshake that produced it (1-cycle load-to-beat latency).
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int LOFF = mod_n(longint'(l) * longint'(SINV), N);
      logic [IW-1:0] idx;
      assign idx    = acc_d + IW'(LOFF);
      assign hit[l] = ({1'b0, idx} < q_d);
   end

   always_comb begin
      bits_d = bits_q;
      if (start_i || adv_i) bits_d = hit;
      else if (stop_i)      bits_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         acc_q  <= IW'(INIT);
         bits_q <= '0;
      end else begin
         q_q    <= q_d;
         acc_q  <= acc_d;
         bits_q <= bits_d;
      end
   end

   assign bits_o = bits_q;

endmodule

// File: rtl/weyl_stream_gen.sv
// ---------------------------------------------------------------------------
// weyl_stream_gen
// Emits, per load, an N-bit stream per channel in N/LANES beats. Channel c
// has exactly min(quota_c, N) ones, placed at positions B_c + k*STRIDE.
//   clk  : clock
//   rst  : synchronous active-high reset (aborts any stream)
//   bus  : weyl_stream_gen_if.slave (load and beat handshakes)
// ---------------------------------------------------------------------------
module weyl_stream_gen
   import weyl_pkg::*;
#(
   parameter int BITSTREAM = 64,
   parameter int LANES     = 8,
   parameter int CHANNELS  = 2,
   parameter int BASE      = 61,
   parameter int STRIDE    = 17,
   parameter int CH_OFFSET = 0
) (
   input logic               clk,
   input logic               rst,
   weyl_stream_gen_if.slave  bus
);

   localparam int N      = BITSTREAM;
   localparam int NBEATS = N / LANES;
   localparam int TW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int SINV   = mod_inv(STRIDE, N);
   localparam int STEP   = mod_n(longint'(LANES) * longint'(SINV), N);

   if ((STRIDE % 2) == 0) begin : g_err_stride
      $error("weyl_stream_gen: STRIDE must be odd");
   end
   if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_err_len
      $error("weyl_stream_gen: BITSTREAM must be a power of 2, >= 2");
   end
   if (LANES < 1 || (BITSTREAM % LANES) != 0) begin : g_err_lanes
      $error("weyl_stream_gen: LANES must divide BITSTREAM");
   end

   state_e          state_q;
   logic [TW-1:0]   t_q;
   logic            last_q;
   logic            load_hs, out_hs, adv, stop;
   logic [CHANNELS-1:0][LANES-1:0] bits;

   // Ready on the last-beat handshake too, so a waiting load chains with no
   // gap cycle.
   assign bus.load_ready = !rst &&
                           ((state_q == IDLE) || (bus.out_ready && last_q));
   assign bus.out_valid  = !rst && (state_q == STREAM);
   assign bus.out_last   = bus.out_valid && last_q;
   assign bus.out_bits   = bus.out_valid ? bits : '0;

   assign load_hs = bus.load_valid && bus.load_ready;
   assign out_hs  = bus.out_valid && bus.out_ready;
   assign adv     = out_hs && !last_q;
   assign stop    = out_hs && last_q && !load_hs;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         last_q  <= 1'b0;
      end else if (load_hs) begin
         state_q <= STREAM;
         t_q     <= '0;
         last_q  <= (NBEATS == 1);
      end else if (out_hs) begin
         if (last_q) begin
            state_q <= IDLE;
            t_q     <= '0;
            last_q  <= 1'b0;
         end else begin
            t_q     <= t_q + 1'b1;
            last_q  <= ((t_q + 1'b1) == TW'(NBEATS - 1));
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      localparam int BC   = mod_n(longint'(BASE) + longint'(c) * longint'(CH_OFFSET), N);
      localparam int INIT = mod_n(longint'(N - BC) * longint'(SINV), N);
      weyl_stream_chan #(
         .N     (N),
         .LANES (LANES),
         .SINV  (SINV),
         .INIT  (INIT),
         .STEP  (STEP)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .start_i (load_hs),
         .adv_i   (adv),
         .stop_i  (stop),
         .quota_i (bus.quota[c]),
         .bits_o  (bits[c])
      );
   end

endmodule

// File: tb/tb_weyl_stream_gen.sv
module tb_weyl_stream_gen;
   localparam int N = 64, L = 8, C = 2, NB = N / L, QW = 7;
   localparam int BASE = 61, STRIDE = 17, CH_OFFSET = 0, MAXW = 400;

   typedef logic [C-1:0][L-1:0] bits_t;
   typedef struct {
      bits_t bits;
      logic  last;
   } beat_t;

   beat_t q_exp[$];
   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    n_cmp = 0, n_err = 0, popped = 0;

   always #5 clk = ~clk;

   weyl_stream_gen_if #(.CHANNELS(C), .LANES(L), .QW(QW)) bus ();

   weyl_stream_gen #(
      .BITSTREAM(N), .LANES(L), .CHANNELS(C),
      .BASE(BASE), .STRIDE(STRIDE), .CH_OFFSET(CH_OFFSET)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: ones are placed by walking k = 0..Q-1 over B + k*STRIDE.
   function automatic void push_stream(input int q0, input int q1);
      bit    s [C][N];
      int    qs [C];
      beat_t e;
      qs[0] = q0;
      qs[1] = q1;
      for (int c = 0; c < C; c++) begin
         int b, qe;
         for (int p = 0; p < N; p++) s[c][p] = 1'b0;
         b  = (BASE + c * CH_OFFSET) % N;
         qe = (qs[c] > N) ? N : qs[c];
         for (int k = 0; k < qe; k++) s[c][(b + k * STRIDE) % N] = 1'b1;
      end
      for (int t = 0; t < NB; t++) begin
         for (int c = 0; c < C; c++)
            for (int l = 0; l < L; l++) e.bits[c][l] = s[c][t * L + l];
         e.last = (t == NB - 1);
         q_exp.push_back(e);
      end
   endfunction

   // Monitor / scoreboard
   initial begin
      bits_t pb = '0;
      logic  pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b1;
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (pv && !pr && !prst) begin
               chk("stall_valid", 64'(bus.out_valid), 64'd1);
               chk("stall_bits", 64'(bus.out_bits), 64'(pb));
               chk("stall_last", 64'(bus.out_last), 64'(pl));
            end
            if (!bus.out_valid) chk("idle_bits_zero", 64'(bus.out_bits), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
               if (q_exp.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_beat: got %0h, expected no beat", bus.out_bits);
               end else begin
                  e = q_exp.pop_front();
                  chk("beat_bits", 64'(bus.out_bits), 64'(e.bits));
                  chk("beat_last", 64'(bus.out_last), 64'(e.last));
                  popped++;
               end
            end
         end
         pv = bus.out_valid; pr = bus.out_ready; pb = bus.out_bits;
         pl = bus.out_last;  prst = rst;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!bus.load_ready && n < MAXW) begin step(); n++; end
      if (n >= MAXW) chk(nm, 64'd0, 64'd1);
   endtask

   task automatic send_load(input int q0, input int q1);
      push_stream(q0, q1);
      bus.load_valid = 1'b1;
      bus.quota[0]   = QW'(q0);
      bus.quota[1]   = QW'(q1);
      wait_ready("load_timeout");
      step();
      bus.load_valid = 1'b0;
      bus.quota[0]   = QW'($urandom);
      bus.quota[1]   = QW'($urandom);
   endtask

   task automatic wait_popped(input int target);
      int n = 0;
      while (popped < target && n < MAXW) begin step(); n++; end
      if (n >= MAXW) chk("beat_timeout", 64'(popped), 64'(target));
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      while (q_exp.size() != 0 && n < MAXW) begin
         bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         step();
         n++;
      end
      if (q_exp.size() != 0) chk("drain_timeout", 64'(q_exp.size()), 64'd0);
      bus.out_ready = 1'b1;
   endtask

   initial begin
      int c0, n;
      bus.load_valid = 1'b0;
      bus.quota      = '0;
      bus.out_ready  = 1'b1;
      rst            = 1'b1;
      step(); step();
      chk("rst_load_ready", 64'(bus.load_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_load_ready", 64'(bus.load_ready), 64'd1);
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("post_rst_out_bits", 64'(bus.out_bits), 64'd0);
      chk("post_rst_out_last", 64'(bus.out_last), 64'd0);

      // All-zero / all-one channels, single and double ones, saturation
      send_load(0, 64);  drain(0);
      send_load(1, 2);   drain(0);
      send_load(70, 32); drain(0);

      // Backpressure held 3 cycles on beat 2
      c0 = popped;
      send_load(3, 40);
      wait_popped(c0 + 2);
      bus.out_ready = 1'b0;
      step(); step(); step();
      bus.out_ready = 1'b1;
      drain(0);
      chk("stall_beat_count", 64'(popped - c0), 64'(NB));

      // Load held across the stream: second quota must wait for the last beat
      c0 = popped;
      push_stream(10, 50);
      push_stream(33, 7);
      bus.load_valid = 1'b1;
      bus.quota[0] = QW'(10); bus.quota[1] = QW'(50);
      wait_ready("b2b_load_timeout");
      step();
      bus.quota[0] = QW'(33); bus.quota[1] = QW'(7);
      n = 0;
      while (!(bus.out_valid && bus.out_last) && n < MAXW) begin step(); n++; end
      chk("b2b_last_load_ready", 64'(bus.load_ready), 64'd1);
      step();
      bus.load_valid = 1'b0;
      chk("b2b_no_gap_valid", 64'(bus.out_valid), 64'd1);
      chk("b2b_new_beat0_last", 64'(bus.out_last), 64'd0);
      drain(0);
      chk("b2b_beat_count", 64'(popped - c0), 64'(2 * NB));

      // Reset in the middle of a stream
      c0 = popped;
      send_load(9, 20);
      wait_popped(c0 + 4);
      rst = 1'b1;
      q_exp.delete();
      step();
      rst = 1'b0;
      #1;
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_load_ready", 64'(bus.load_ready), 64'd1);
      chk("abort_out_bits", 64'(bus.out_bits), 64'd0);
      chk("abort_beats_seen", 64'(popped - c0), 64'd4);
      c0 = popped;
      send_load(5, 5);
      drain(0);
      chk("reload_beat_count", 64'(popped - c0), 64'(NB));

      // Random quotas (including over-range) with random backpressure
      for (int i = 0; i < 12; i++) begin
         send_load(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
         drain(1);
      end

      step(); step(); step();
      chk("queue_empty", 64'(q_exp.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/weyl_stream_gen.md
WEYL_STREAM_GEN -- requirements
Module: weyl_stream_gen

Interface
REQ-001 Parameter BITSTREAM, default 64, stream length N in bits per quota; SHALL be a power of 2, at least 2.
REQ-002 Parameter LANES, default 8, bits per channel per beat; SHALL divide BITSTREAM.
REQ-003 Parameter CHANNELS, default 2, independent output channels.
REQ-004 Parameter BASE, default 61, position of index 0 for channel 0, taken mod N.
REQ-005 Parameter STRIDE, default 17, Weyl stride; SHALL be odd, so it is invertible mod N.
REQ-006 Parameter CH_OFFSET, default 0, base increment per channel, mod N.
REQ-007 clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 load_valid  in  1  quota vector offered.
REQ-010 load_ready  out  1  block accepts quota vector.
REQ-011 quota  in  CHANNELS x (clog2(N)+1)  per-channel ones-count request.
REQ-012 out_valid  out  1  beat present.
REQ-013 out_ready  in  1  consumer accepts beat.
REQ-014 out_bits  out  CHANNELS x LANES  beat data; lane l of beat t is stream position p = t*LANES + l.
REQ-015 out_last  out  1  asserted with the final beat, t = N/LANES - 1.

Function
REQ-016 Channel c base: B_c = (BASE + c*CH_OFFSET) mod N; SINV = STRIDE^-1 mod N (17 -> 49 for N=64).
REQ-017 Bit at position p of channel c SHALL be 1 iff ((p - B_c)*SINV mod N) < Q_c, where Q_c = min(quota_c, N) is latched at load.
REQ-018 Each stream SHALL contain exactly Q_c ones per channel; quota > N saturates to all-ones.
REQ-019 FSM states IDLE and STREAM; reset enters IDLE.
REQ-020 IDLE: load_ready=1, out_valid=0; on load_valid, latch Q and go to STREAM with beat counter t=0.
REQ-021 STREAM: out_valid=1; on out_ready, advance t; if out_last, end the stream.
REQ-022 Load-to-first-beat latency SHALL be 1 cycle: handshake at edge k, beat 0 valid in the cycle after edge k.
REQ-023 While out_valid=1 and out_ready=0, out_bits, out_last and t SHALL hold stable.
REQ-024 On a last-beat handshake, load_ready SHALL be 1 in that same cycle; a simultaneous load SHALL start a new stream at beat 0 with no gap cycle. Without a load, the FSM returns to IDLE.
REQ-025 quota SHALL be ignored whenever load_ready=0; the latched Q is immutable for the rest of the stream.
REQ-026 Index generation SHALL be incremental: per-channel accumulator of lane-0 index, advanced by LANES*SINV mod N per beat; lane l adds l*SINV. No multiplier on the datapath.
REQ-027 Index arithmetic SHALL be clog2(N) bits, wrapping mod N; comparison width SHALL be clog2(N)+1.
REQ-028 out_bits SHALL be registered; out_bits=0 whenever out_valid=0.

Reset
REQ-029 When rst=1 at an edge: state=IDLE, t=0, Q=0, accumulators=(-B_c)*SINV mod N, out_bits=0, out_valid=0, out_last=0.
REQ-030 While rst=1, load_ready and out_valid SHALL be forced to 0.
REQ-031 Reset mid-stream SHALL abort the stream with no further beats; the next load starts at beat 0.

Structure
REQ-032 Package weyl_pkg SHALL hold: state enum, modular-inverse constant function, and index/quota width helpers.
REQ-033 Sub-module weyl_stream_chan SHALL be instantiated per channel, holding the Q register, index accumulator and LANES comparators. The top holds the FSM, beat counter and handshakes.
REQ-034 Elaboration SHALL fail on even STRIDE, non-power-of-2 BITSTREAM, or LANES not dividing BITSTREAM.

Verification
REQ-035 Defaults; quota={0,64}, out_ready=1 -> 8 beats, ch0 all 0, ch1 all 1, out_last only on beat 7.
REQ-036 quota={1,2} -> ch0 single 1 at beat 7 lane 5 (p=61); ch1 ones at p=61 and p=14 (beat 1 lane 6); all else 0.
REQ-037 quota={70,32} -> ch0 all 1 (saturated); ch1 popcount 32, bit p matches REQ-017 for all 64 p.
REQ-038 out_ready low 3 cycles at beat 2 -> out_bits/out_last stable, no beat lost or duplicated, 8 beats total.
REQ-039 Load held valid with new quota during last beat, out_ready=1 -> new stream beat 0 next cycle, no idle cycle.
REQ-040 rst pulsed at beat 4 -> out_valid=0 next cycle, IDLE; reload quota={5,5} -> full correct 8-beat stream.
